// File: rtl/vga_pattern_sequencer.sv
// Picks the test pattern the VGA generator draws and switches it only on frame boundaries.
// Latency: every frame_start-driven update is visible 1 clk after the frame_start cycle.
// Backpressure: none; ena low freezes all state and suppresses pattern_change.
// Build option: define VGA_SEQ_SHUFFLE_EN for LFSR-driven auto-mode pattern order.
module vga_pattern_sequencer #(
  parameter int NUM_PATTERNS       = 8,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BLANK_FRAMES       = 2,
  parameter int DEBOUNCE_CYCLES    = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_start,
  input  logic       auto_en,
  input  logic [2:0] manual_sel,
  input  logic       step,
  output logic [2:0] pattern_sel,
  output logic       blank,
  output logic       pattern_change,
  output logic [7:0] frame_cnt
);

  localparam int DW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DW-1:0] DWELL_LAST = DW'(FRAMES_PER_PATTERN - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    SEL_LAST   = 3'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_BLANK} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   blank_cnt, blank_cnt_d;
  logic [2:0]      sel_d;
  logic            blank_d, change_d;
  logic [7:0]      fcnt_d;

  logic            sync0, sync1, db_level, db_rise, step_pending;
  logic [CW-1:0]   db_cnt;

  logic            fs;
  logic            advance, blank_done;
  logic [2:0]      manual_clamped, seq_next, auto_target, target;

  assign fs = frame_start & ena;

  // Synchronise the raw button and accept a new level only after it has been stable long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (ena) begin
      sync0 <= step;
      sync1 <= sync0;
      if (sync1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync1;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  assign db_rise = ena & sync1 & ~db_level & (db_cnt == DB_LAST);

  // Latch one step request per frame; a press landing on frame_start carries into the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_pending <= 1'b0;
    end else if (ena) begin
      if (db_rise)
        step_pending <= 1'b1;
      else if (frame_start)
        step_pending <= 1'b0;
    end
  end

`ifdef VGA_SEQ_SHUFFLE_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR (taps 8,6,5,4) advanced once per enabled frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr_q <= 8'hA5;
    else if (fs)
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
`endif

  // Pattern the sequencer would move to if it switched this frame
  always_comb begin
    manual_clamped = ({1'b0, manual_sel} >= 4'(NUM_PATTERNS)) ? SEL_LAST : manual_sel;
    seq_next       = (pattern_sel == SEL_LAST) ? 3'd0 : pattern_sel + 3'd1;
    auto_target    = seq_next;
`ifdef VGA_SEQ_SHUFFLE_EN
    if (({1'b0, lfsr_q[2:0]} < 4'(NUM_PATTERNS)) && (lfsr_q[2:0] != pattern_sel))
      auto_target = lfsr_q[2:0];
`endif
    target = auto_en ? auto_target : manual_clamped;
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pattern_sel    <= 3'd0;
      blank          <= 1'b1;
      pattern_change <= 1'b0;
      frame_cnt      <= 8'd0;
      dwell_q        <= '0;
      blank_cnt      <= '0;
    end else if (ena) begin
      state_q        <= state_d;
      pattern_sel    <= sel_d;
      blank          <= blank_d;
      pattern_change <= change_d;
      frame_cnt      <= fcnt_d;
      dwell_q        <= dwell_d;
      blank_cnt      <= blank_cnt_d;
    end else begin
      pattern_change <= 1'b0;
    end
  end

  // Next-state decision, taken only at an enabled frame boundary
  always_comb begin
    state_d    = state_q;
    advance    = 1'b0;
    blank_done = 1'b0;
    if (fs) begin
      case (state_q)
        ST_IDLE: state_d = ST_SHOW;
        ST_SHOW: begin
          advance = auto_en ? ((dwell_q == DWELL_LAST) || step_pending)
                            : (manual_clamped != pattern_sel);
          if (advance && (BLANK_FRAMES > 0))
            state_d = ST_BLANK;
        end
        ST_BLANK: begin
          blank_done = (blank_cnt == BLANK_LAST);
          if (blank_done)
            state_d = ST_SHOW;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output and counter updates that accompany each transition
  always_comb begin
    sel_d       = pattern_sel;
    blank_d     = blank;
    change_d    = 1'b0;
    fcnt_d      = frame_cnt;
    dwell_d     = dwell_q;
    blank_cnt_d = blank_cnt;
    if (fs) begin
      case (state_q)
        ST_IDLE: begin
          sel_d       = auto_en ? 3'd0 : manual_clamped;
          blank_d     = 1'b0;
          change_d    = 1'b1;
          fcnt_d      = 8'd0;
          dwell_d     = '0;
          blank_cnt_d = '0;
        end
        ST_SHOW: begin
          // Manual mode keeps the dwell at zero so re-entering auto starts a fresh dwell
          dwell_d = (auto_en && !advance) ? dwell_q + DW'(1) : '0;
          fcnt_d  = (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;
          if (advance) begin
            if (BLANK_FRAMES > 0) begin
              blank_d     = 1'b1;
              blank_cnt_d = '0;
            end else begin
              sel_d    = target;
              change_d = 1'b1;
              fcnt_d   = 8'd0;
            end
          end
        end
        ST_BLANK: begin
          if (blank_done) begin
            blank_d     = 1'b0;
            sel_d       = target;
            change_d    = 1'b1;
            fcnt_d      = 8'd0;
            dwell_d     = '0;
            blank_cnt_d = '0;
          end else begin
            blank_cnt_d = blank_cnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
